// File: rtl/timer_counter_if.sv
// timer_counter_if: word-addressed register port between the system bridge
// and a timer_counter instance.
//   addr  [29:0]  word address [31:2]; the timer decodes only addr[1:0] (byte addr[3:2])
//   we            write enable, full-word stores only
//   din   [31:0]  write data
//   dout  [31:0]  read data, combinational from the address
//   irq           interrupt request toward the CPU
// master: bridge side, slave: timer side.
interface timer_counter_if;
    logic [29:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, output we, output din, input dout, input irq);
    modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer with a level interrupt.
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    timer_counter_if.slave (addr, we, din, dout, irq)
// Register map by byte addr[3:2]:
//   0 CTRL   {IM, MODE[1:0], EN}, upper bits read 0
//   1 PRESET reload value
//   2 COUNT  read-only current count
//   3 unmapped, reads 0
module timer_counter (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    logic [1:0]  sel;

    // Word address bits above the register select are decoded by the bridge.
    logic unused_addr;
    assign unused_addr = ^bus.addr[29:2];

    assign sel = bus.addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            flag   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl[0]) begin
                        state <= S_LOAD;
                        flag  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Samples PRESET before any write landing on this same edge.
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= '0;
                        flag  <= 1'b1;
                        state <= S_INT;
                    end
                end
                S_INT: begin
                    if (ctrl[2:1] == 2'b00) begin
                        ctrl[0] <= 1'b0;
                    end else begin
                        flag <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Placed after the FSM so a CPU write to CTRL overrides the
            // one-shot EN clear on the same edge.
            if (bus.we) begin
                case (sel)
                    2'd0:    ctrl   <= bus.din[3:0];
                    2'd1:    preset <= bus.din;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.dout = '0;
        case (sel)
            2'd0:    bus.dout = {28'd0, ctrl};
            2'd1:    bus.dout = preset;
            2'd2:    bus.dout = count;
            default: bus.dout = '0;
        endcase
    end

    assign bus.irq = ctrl[3] & flag;

endmodule
